// File: rtl/pipe_elastic_slice.sv
// pipe_elastic_slice
//
// Elastic pipeline boundary stage. This is a valid/ready FIFO slice of
// configurable width and depth, with an optional same-cycle bypass and a
// synchronous flush. It never drops or duplicates a beat, except on flush
// or reset.
//
// None of the outputs depend combinationally on deq_ready, so no ready
// path crosses the boundary. The cost is that a full slice refuses an
// enqueue even when a dequeue fires in the same cycle.
//
// Parameters
//   WIDTH   payload bits per entry (>= 1)
//   DEPTH   number of entries (>= 1; need not be a power of two)
//   BYPASS  1: an empty slice forwards enq -> deq in the same cycle
//
// Ports
//   CLK        clock
//   RST        asynchronous reset, active high
//   enq_valid  upstream beat valid
//   enq_data   upstream payload
//   enq_ready  slice accepts a beat this cycle
//   deq_valid  downstream beat valid
//   deq_data   head entry, or enq_data when bypassing
//   deq_ready  downstream accepts
//   flush      discard all contents at the next edge
//   count      current occupancy

module pipe_elastic_slice #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned BYPASS = 0
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       enq_valid,
   input  logic [WIDTH-1:0]           enq_data,
   output logic                       enq_ready,
   output logic                       deq_valid,
   output logic [WIDTH-1:0]           deq_data,
   input  logic                       deq_ready,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CW       = $clog2(DEPTH + 1);
   localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam bit          BypassEn = (BYPASS != 0);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic             mem_we;

   logic             full, empty;
   logic             enq_fire, deq_fire, bypass_fire;

   // Explicit wrap: with a non-power-of-2 depth the natural pointer
   // overflow would land on an entry that does not exist.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (DEPTH == 1) begin
         nxt = '0;
      end else if (ptr == PW'(DEPTH - 1)) begin
         nxt = '0;
      end else begin
         nxt = ptr + PW'(1);
      end
      return nxt;
   endfunction

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // ------------------------------------------------------------------
   // Handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      enq_ready = ~RST & ~flush & ~full;
      deq_valid = ~flush & (~empty | (BypassEn & enq_valid));
      // The enq_data path exists only when bypass is enabled. Otherwise
      // the head entry is shown, which is 0 straight out of reset.
      if (BypassEn && empty) begin
         deq_data = enq_data;
      end else begin
         deq_data = mem_q[head_q];
      end
   end

   assign enq_fire    = enq_valid & enq_ready;
   assign deq_fire    = deq_valid & deq_ready;
   // The beat passes straight through, so no state changes.
   assign bypass_fire = BypassEn & empty & enq_fire & deq_fire;

   assign count = count_q;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      mem_we  = 1'b0;

      if (flush) begin
         // Both valids are gated during flush, so no fire can coincide
         // with it. The memory contents are left as they are.
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (!bypass_fire) begin
         if (enq_fire) begin
            mem_we = 1'b1;
            tail_d = ptr_inc(tail_q);
         end
         if (deq_fire) begin
            head_d = ptr_inc(head_q);
         end
         unique case ({enq_fire, deq_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // The storage is reset too, so deq_data reads as 0 while RST is high.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (mem_we) begin
         mem_q[tail_q] <= enq_data;
      end
   end

endmodule

// File: tb/tb_pipe_elastic_slice.sv
// Directed testbench for pipe_elastic_slice.
//
// Four instances share one clock and reset:
//   a: DEPTH=4, BYPASS=0  (fill/backpressure, flush)
//   b: DEPTH=2, BYPASS=0  (streaming, async reset mid-stream)
//   c: DEPTH=3, BYPASS=0  (pointer wrap with random stalls)
//   d: DEPTH=2, BYPASS=1  (same-cycle bypass)
//
// Inputs change 1 time unit after each rising edge. Outputs are checked
// 1 unit later, well before the next rising edge.

module tb_pipe_elastic_slice;

   logic CLK = 1'b0;
   logic RST;

   always #5 CLK = ~CLK;

   // instance a
   logic       a_enq_valid, a_enq_ready, a_deq_valid, a_deq_ready, a_flush;
   logic [7:0] a_enq_data, a_deq_data;
   logic [2:0] a_count;
   // instance b
   logic       b_enq_valid, b_enq_ready, b_deq_valid, b_deq_ready, b_flush;
   logic [7:0] b_enq_data, b_deq_data;
   logic [1:0] b_count;
   // instance c
   logic       c_enq_valid, c_enq_ready, c_deq_valid, c_deq_ready, c_flush;
   logic [7:0] c_enq_data, c_deq_data;
   logic [1:0] c_count;
   // instance d
   logic       d_enq_valid, d_enq_ready, d_deq_valid, d_deq_ready, d_flush;
   logic [7:0] d_enq_data, d_deq_data;
   logic [1:0] d_count;

   pipe_elastic_slice #(.WIDTH(8), .DEPTH(4), .BYPASS(0)) u_a (
      .CLK(CLK), .RST(RST), .enq_valid(a_enq_valid), .enq_data(a_enq_data),
      .enq_ready(a_enq_ready), .deq_valid(a_deq_valid), .deq_data(a_deq_data),
      .deq_ready(a_deq_ready), .flush(a_flush), .count(a_count)
   );
   pipe_elastic_slice #(.WIDTH(8), .DEPTH(2), .BYPASS(0)) u_b (
      .CLK(CLK), .RST(RST), .enq_valid(b_enq_valid), .enq_data(b_enq_data),
      .enq_ready(b_enq_ready), .deq_valid(b_deq_valid), .deq_data(b_deq_data),
      .deq_ready(b_deq_ready), .flush(b_flush), .count(b_count)
   );
   pipe_elastic_slice #(.WIDTH(8), .DEPTH(3), .BYPASS(0)) u_c (
      .CLK(CLK), .RST(RST), .enq_valid(c_enq_valid), .enq_data(c_enq_data),
      .enq_ready(c_enq_ready), .deq_valid(c_deq_valid), .deq_data(c_deq_data),
      .deq_ready(c_deq_ready), .flush(c_flush), .count(c_count)
   );
   pipe_elastic_slice #(.WIDTH(8), .DEPTH(2), .BYPASS(1)) u_d (
      .CLK(CLK), .RST(RST), .enq_valid(d_enq_valid), .enq_data(d_enq_data),
      .enq_ready(d_enq_ready), .deq_valid(d_deq_valid), .deq_data(d_deq_data),
      .deq_ready(d_deq_ready), .flush(d_flush), .count(d_count)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fill_data [4];
      logic [7:0] drain_data [5];
      int         drain_cnt [5];
      int         sent, recv, mcnt, cyc;
      logic       ef, df;

      fill_data   = '{8'h11, 8'h22, 8'h33, 8'h44};
      drain_data  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      drain_cnt   = '{4, 3, 3, 2, 1};

      RST = 1'b1;
      {a_enq_valid, a_deq_ready, a_flush} = '0;
      {b_enq_valid, b_deq_ready, b_flush} = '0;
      {c_enq_valid, c_deq_ready, c_flush} = '0;
      {d_enq_valid, d_deq_ready, d_flush} = '0;
      a_enq_data = '0; b_enq_data = '0; c_enq_data = '0;
      d_enq_data = 8'h5A;
      d_enq_valid = 1'b1;

      // ---------------- reset state ----------------
      #2;
      chk("rst_a_count", a_count, 0);
      chk("rst_a_enq_ready", a_enq_ready, 0);
      chk("rst_a_deq_valid", a_deq_valid, 0);
      chk("rst_a_deq_data", a_deq_data, 0);
      chk("rst_d_byp_valid", d_deq_valid, 1);
      chk("rst_d_byp_data", d_deq_data, 8'h5A);
      d_enq_valid = 1'b0;
      @(posedge CLK);
      step();
      RST = 1'b0;
      #1;
      chk("post_rst_enq_ready", a_enq_ready, 1);

      // ---------------- fill DEPTH=4, hold 5th beat ----------------
      step();
      for (int i = 0; i < 4; i++) begin
         a_enq_valid = 1'b1;
         a_enq_data  = fill_data[i];
         #1;
         chk("fill_enq_ready", a_enq_ready, 1);
         step();
         chk("fill_count", a_count, i + 1);
      end
      a_enq_data = 8'h55;
      #1;
      chk("full_enq_ready", a_enq_ready, 0);
      chk("full_deq_valid", a_deq_valid, 1);
      chk("full_head_data", a_deq_data, 8'h11);
      step();
      step();
      chk("full_hold_count", a_count, 4);
      // Full slice refuses 0x55 even while dequeuing in the first cycle.
      a_deq_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) a_enq_valid = 1'b0;
         #1;
         chk("drain_valid", a_deq_valid, 1);
         chk("drain_data", a_deq_data, drain_data[k]);
         chk("drain_count", a_count, drain_cnt[k]);
         if (k == 0) chk("drain_full_ready", a_enq_ready, 0);
         if (k == 1) chk("drain_reopen_ready", a_enq_ready, 1);
         step();
      end
      chk("drain_empty_count", a_count, 0);
      chk("drain_empty_valid", a_deq_valid, 0);
      a_deq_ready = 1'b0;

      // ---------------- streaming DEPTH=2 ----------------
      b_deq_ready = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         b_enq_valid = (i < 16);
         b_enq_data  = 8'(i);
         #1;
         if (i == 0) begin
            chk("strm_first_valid", b_deq_valid, 0);
         end else begin
            chk("strm_valid", b_deq_valid, 1);
            chk("strm_data", b_deq_data, i - 1);
            chk("strm_count", b_count, 1);
         end
         step();
      end
      chk("strm_end_count", b_count, 0);
      chk("strm_end_valid", b_deq_valid, 0);
      b_deq_ready = 1'b0;

      // ---------------- wrap DEPTH=3, random stalls ----------------
      sent = 0; recv = 0; mcnt = 0; cyc = 0;
      while (recv < 10 && cyc < 200) begin
         c_enq_valid = (sent < 10);
         c_enq_data  = 8'(8'hA0 + sent);
         c_deq_ready = (cyc > 60) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         chk("wrap_count", c_count, mcnt);
         chk("wrap_enq_ready", c_enq_ready, (mcnt != 3));
         chk("wrap_deq_valid", c_deq_valid, (mcnt != 0));
         ef = c_enq_valid & c_enq_ready;
         df = c_deq_valid & c_deq_ready;
         if (df) begin
            chk("wrap_data", c_deq_data, 8'hA0 + recv);
            recv++;
         end
         if (ef) sent++;
         mcnt = mcnt + int'(ef) - int'(df);
         step();
         cyc++;
      end
      chk("wrap_all_received", recv, 10);
      c_enq_valid = 1'b0;
      c_deq_ready = 1'b0;

      // ---------------- bypass DEPTH=2 ----------------
      d_enq_valid = 1'b1;
      d_enq_data  = 8'hAB;
      d_deq_ready = 1'b1;
      #1;
      chk("byp_valid", d_deq_valid, 1);
      chk("byp_data", d_deq_data, 8'hAB);
      step();
      d_enq_valid = 1'b0;
      #1;
      chk("byp_count", d_count, 0);
      chk("byp_after_valid", d_deq_valid, 0);
      d_enq_valid = 1'b1;
      d_deq_ready = 1'b0;
      #1;
      chk("byp_stall_valid", d_deq_valid, 1);
      step();
      d_enq_valid = 1'b0;
      d_enq_data  = 8'hCD;
      #1;
      chk("byp_stored_count", d_count, 1);
      chk("byp_stored_valid", d_deq_valid, 1);
      chk("byp_stored_data", d_deq_data, 8'hAB);
      d_deq_ready = 1'b1;
      step();
      chk("byp_drained_count", d_count, 0);
      d_deq_ready = 1'b0;

      // ---------------- flush DEPTH=4 holding 3 ----------------
      for (int i = 1; i <= 3; i++) begin
         a_enq_valid = 1'b1;
         a_enq_data  = 8'(i);
         step();
      end
      chk("pre_flush_count", a_count, 3);
      a_flush     = 1'b1;
      a_enq_data  = 8'h99;
      #1;
      chk("flush_deq_valid", a_deq_valid, 0);
      chk("flush_enq_ready", a_enq_ready, 0);
      step();
      a_flush     = 1'b0;
      a_enq_valid = 1'b0;
      #1;
      chk("post_flush_count", a_count, 0);
      chk("post_flush_valid", a_deq_valid, 0);
      chk("post_flush_ready", a_enq_ready, 1);
      a_enq_valid = 1'b1;
      a_enq_data  = 8'h44;
      step();
      a_enq_valid = 1'b0;
      #1;
      chk("flush_reuse_valid", a_deq_valid, 1);
      chk("flush_reuse_data", a_deq_data, 8'h44);
      chk("flush_reuse_count", a_count, 1);

      // ---------------- async reset mid-stream DEPTH=2 ----------------
      b_enq_valid = 1'b1;
      b_enq_data  = 8'h01;
      step();
      b_enq_data  = 8'h02;
      step();
      b_enq_valid = 1'b0;
      #1;
      chk("pre_rst_count", b_count, 2);
      chk("pre_rst_valid", b_deq_valid, 1);
      #1;
      RST = 1'b1;
      #1;
      chk("async_rst_count", b_count, 0);
      chk("async_rst_valid", b_deq_valid, 0);
      chk("async_rst_ready", b_enq_ready, 0);
      #1;
      RST = 1'b0;
      b_enq_valid = 1'b1;
      b_enq_data  = 8'h07;
      #1;
      chk("post_arst_ready", b_enq_ready, 1);
      step();
      b_enq_valid = 1'b0;
      #1;
      chk("post_arst_valid", b_deq_valid, 1);
      chk("post_arst_data", b_deq_data, 8'h07);
      chk("post_arst_count", b_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_elastic_slice.md
# pipe_elastic_slice

Parametrised elastic pipeline boundary stage: a valid/ready FIFO slice of configurable width and depth, with optional same-cycle bypass and a synchronous flush. It sits between core pipeline stages, e.g. BRU/ALU writeback to PRF or branch notification to ROB. It replaces free-running boundary flops with backpressure-correct buffering that never drops or duplicates a beat. All outputs are decoupled from `deq_ready`, so no combinational ready path crosses the boundary.

## Interface
- `WIDTH`, 32: payload bits per entry (≥1).
- `DEPTH`, 2: entry count (≥1; non-power-of-2 allowed).
- `BYPASS`, 0: 1 lets an empty slice pass enq→deq in the same cycle.
- `CLK` input 1: clock. One clock only.
- `RST` input 1: asynchronous, active-high reset.
- `enq_valid` input 1: upstream beat valid.
- `enq_data` input WIDTH: upstream payload.
- `enq_ready` output 1: slice accepts a beat this cycle.
- `deq_valid` output 1: downstream beat valid.
- `deq_data` output WIDTH: downstream payload (head entry, or `enq_data` on bypass).
- `deq_ready` input 1: downstream accepts.
- `flush` input 1: discard all contents (e.g. on mispredict or restart).
- `count` output $clog2(DEPTH+1): current occupancy.

## Operation
- Circular buffer `mem[DEPTH]` with `head`, `tail` and `count` registers.
  - Pointers advance by 1 and wrap explicitly from DEPTH-1 to 0. Never rely on natural wrap.
  - For DEPTH=1 the pointers are constant 0.
- Enqueue fire = `enq_valid & enq_ready`. Dequeue fire = `deq_valid & deq_ready`.
- `enq_ready = ~RST & ~flush & (count != DEPTH)`.
  - It does not look at `deq_ready`.
  - A full slice refuses enqueue even when a dequeue fires in the same cycle.
  - Consequence: DEPTH=1 gives at most 50% throughput; DEPTH≥2 sustains 1 beat/cycle.
- `deq_valid = ~flush & ((count != 0) | (BYPASS & enq_valid))`.
- `deq_data = (count == 0) ? enq_data : mem[head]`. The `enq_data` path is used only when BYPASS=1.
- Bypass fire happens when count==0, BYPASS=1 and both fires occur. Then nothing is written, pointers hold and count holds at 0.
- Otherwise, register updates per cycle:
  - An enqueue fire writes `mem[tail]` and advances `tail`.
  - A dequeue fire advances `head`.
  - `count += enq_fire - deq_fire`. A simultaneous enqueue and dequeue leaves `count` unchanged.
- Flush priority:
  - In a flush cycle both fires are impossible, since both valids are gated.
  - The next state is `head = tail = count = 0`; `mem` is not cleared.
  - A beat presented with flush is dropped; upstream sees `enq_ready=0` and may hold or retract it.
- Ordering is strict FIFO. No beat is dropped, duplicated or reordered except by flush or reset.
- Invariant: `count ≤ DEPTH` at all times. Verification asserts this, plus no enqueue when full and no dequeue when empty.

## Timing
- Reset (async, while RST=1):
  - `head`, `tail` and `count` are 0 and every `mem` entry is 0.
  - `enq_ready=0`, `deq_valid=0` (unless BYPASS=1 and enq_valid), `deq_data=0`, `count=0`.
  - With BYPASS=1, `deq_data` follows `enq_data` while RST=1.
  - After deassertion, `enq_ready=1` in the first cycle.
- Reset mid-operation: contents are lost immediately, asynchronously. No handshake completes in a cycle where RST is high at the clock edge.
- Latency, BYPASS=0: a beat enqueued at edge N is visible on deq in cycle N+1.
- Latency, BYPASS=1: latency is 0 when the slice is empty; otherwise beats wait behind older entries.
- Full boundary: `enq_ready` falls in the cycle after the enqueue that made count==DEPTH. It rises in the cycle after the first dequeue from full.
- Empty boundary (BYPASS=0): `deq_valid` falls in the cycle after the last dequeue, unless an enqueue fired in that same cycle.
- Flush: takes effect at the next edge. `count=0` and `enq_ready=1` in the cycle after flush deasserts.

## Test plan
- Reset and fill, DEPTH=4, BYPASS=0, deq_ready=0: enqueue 0x11,0x22,0x33,0x44 on consecutive cycles.
  - `count` goes 1,2,3,4 and `enq_ready=0` after the 4th.
  - A 5th beat 0x55 is held and not lost.
  - Then raise deq_ready: output is 0x11,0x22,0x33,0x44,0x55 in order.
- Streaming, DEPTH=2, BYPASS=0, enq_valid=deq_ready=1 for 16 cycles with data=cycle index: output is 0..15, one per cycle with 1-cycle lag, and `count` stays 1.
- Wrap, DEPTH=3: push 10 beats with random deq_ready stalls. All 10 emerge in order and `count` never exceeds 3.
- Bypass, DEPTH=2, BYPASS=1, empty, enq 0xAB with deq_ready=1: `deq_valid=1` and `deq_data=0xAB` the same cycle, `count` stays 0.
  - Repeat with deq_ready=0: the beat is stored, `count=1`, and 0xAB appears next cycle.
- Flush, DEPTH=4 holding 3 beats, pulse flush with enq_valid=1 and data 0x99:
  - During the flush cycle `deq_valid=0` and `enq_ready=0`.
  - Next cycle `count=0` and `deq_valid=0`; 0x99 is absent unless re-presented.
- Async reset mid-stream with count=2: asserting RST between edges clears `count` and `deq_valid` immediately. The first post-reset enqueue 0x7 emerges first.
